// File: rtl/bbc_analog_pkg.sv
// Shared types and ADC mapping for the BBC analog front end.
// Mouse position axes, centring FSM states, signed-to-ADC helper.
package bbc_analog_pkg;

  localparam int POS_MIN = -128;
  localparam int POS_MAX = 127;

  typedef logic signed [8:0] axis_t;

  typedef enum logic {
    IDLE_WAIT,
    DECAY
  } centre_state_e;

  // Signed stick value to the uPD7002 12-bit scale (+127 top, -128 bottom).
  function automatic logic [11:0] to_adc12(input logic signed [7:0] v);
    logic [7:0] b;
    b = 8'hFF - {~v[7], v[6:0]};
    return {b, b[7:4]};
  endfunction

endpackage

// File: rtl/mouse_axis.sv
// One mouse-emulated stick axis: clamp the packet delta, saturate the
// accumulated position, clear it, and step it toward zero on decay.
module mouse_axis
  import bbc_analog_pkg::*;
#(
  parameter int DELTA_MAX = 10,
  parameter bit INVERT    = 1'b0
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       clear,
  input  logic       accept,
  input  logic       sign,
  input  logic [7:0] mag,
  input  logic       decay,
  output axis_t      pos
);

  localparam logic signed [9:0] DMAX = 10'(DELTA_MAX);
  localparam logic signed [9:0] PMAX = 10'(POS_MAX);
  localparam logic signed [9:0] PMIN = 10'(POS_MIN);

  logic signed [8:0] raw;
  logic signed [8:0] half;
  logic signed [9:0] pos_w;
  logic signed [9:0] delta;
  logic signed [9:0] sum;
  axis_t             nxt;

  assign raw   = {sign, mag};
  assign half  = raw >>> 1;
  assign pos_w = {pos[8], pos};

  always_comb begin
    delta = {half[8], half};
    if (delta > DMAX) begin
      delta = DMAX;
    end else if (delta < -DMAX) begin
      delta = -DMAX;
    end
    sum = INVERT ? pos_w - delta : pos_w + delta;
    if (sum > PMAX) begin
      sum = PMAX;
    end else if (sum < PMIN) begin
      sum = PMIN;
    end
    nxt = pos;
    if (accept) begin
      nxt = sum[8:0];
    end else if (decay && pos != '0) begin
      nxt = pos[8] ? pos + 9'sd1 : pos - 9'sd1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset || clear) begin
      pos <= '0;
    end else begin
      pos <= nxt;
    end
  end

endmodule

// File: rtl/bbc_mouse_joystick.sv
// Mouse/joystick arbitration, channel swap and self-centring in front of
// the BBC core ADC channels and fire lines.
module bbc_mouse_joystick
  import bbc_analog_pkg::*;
#(
  parameter int DELTA_MAX   = 10,
  parameter int IDLE_CYCLES = 0,
  parameter int DECAY_STEP  = 65536
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        recentre,
  input  logic        mouse_en,
  input  logic        swap,
  input  logic [24:0] ps2_mouse,
  input  logic [15:0] joy1,
  input  logic [15:0] joy2,
  input  logic [7:0]  joy1_x,
  input  logic [7:0]  joy1_y,
  input  logic [7:0]  joy2_x,
  input  logic [7:0]  joy2_y,
  output logic [11:0] joystick1_x,
  output logic [11:0] joystick1_y,
  output logic [11:0] joystick2_x,
  output logic [11:0] joystick2_y,
  output logic        joystick1_fire,
  output logic        joystick2_fire,
  output logic        emu_active
);

  localparam bit          CENTRE_EN = IDLE_CYCLES > 0;
  localparam logic [31:0] IDLE_LAST = 32'(IDLE_CYCLES - 1);
  localparam logic [31:0] STEP_LAST = 32'(DECAY_STEP - 1);

  logic          stb_q;
  logic          accept;
  logic          clear;
  logic          mfire;
  logic          decay;
  axis_t         mx;
  axis_t         my;
  centre_state_e state;
  centre_state_e state_nxt;
  logic [31:0]   idle_cnt;
  logic [31:0]   idle_nxt;
  logic [31:0]   step_cnt;
  logic [31:0]   step_nxt;
  logic [7:0]    ax;
  logic [7:0]    ay;
  logic          af;
  logic          unused;

  assign accept = (ps2_mouse[24] != stb_q) && mouse_en;
  assign clear  = (joy1 != '0) || recentre || !mouse_en;
  assign unused = ^{joy2[15:5], joy2[3:0], ps2_mouse[7:6],
                    ps2_mouse[3:2], mx[8], my[8]};

  // The strobe is consumed every cycle, including reset and clear.
  always_ff @(posedge clk_sys) begin
    stb_q <= ps2_mouse[24];
    if (reset || clear) begin
      emu_active <= 1'b0;
    end else if (accept) begin
      emu_active <= 1'b1;
    end
    if (reset) begin
      mfire <= 1'b0;
    end else if (accept) begin
      mfire <= |ps2_mouse[1:0];
    end
  end

  mouse_axis #(
    .DELTA_MAX (DELTA_MAX),
    .INVERT    (1'b0)
  ) u_axis_x (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clear   (clear),
    .accept  (accept),
    .sign    (ps2_mouse[4]),
    .mag     (ps2_mouse[15:8]),
    .decay   (decay),
    .pos     (mx)
  );

  mouse_axis #(
    .DELTA_MAX (DELTA_MAX),
    .INVERT    (1'b1)
  ) u_axis_y (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clear   (clear),
    .accept  (accept),
    .sign    (ps2_mouse[5]),
    .mag     (ps2_mouse[23:16]),
    .decay   (decay),
    .pos     (my)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE_WAIT;
      idle_cnt <= '0;
      step_cnt <= '0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_nxt;
      step_cnt <= step_nxt;
    end
  end

  // Decay pulses keep coming once centred; they have no effect at zero.
  always_comb begin
    state_nxt = state;
    idle_nxt  = idle_cnt;
    step_nxt  = step_cnt;
    decay     = 1'b0;
    if (accept) begin
      state_nxt = IDLE_WAIT;
      idle_nxt  = '0;
      step_nxt  = '0;
    end else if (CENTRE_EN) begin
      unique case (state)
        IDLE_WAIT: begin
          idle_nxt = idle_cnt + 32'd1;
          if (idle_cnt == IDLE_LAST) begin
            state_nxt = DECAY;
            step_nxt  = '0;
          end
        end
        DECAY: begin
          if (step_cnt == STEP_LAST) begin
            step_nxt = '0;
            decay    = 1'b1;
          end else begin
            step_nxt = step_cnt + 32'd1;
          end
        end
      endcase
    end
  end

  always_comb begin
    ax = joy1_x;
    ay = joy1_y;
    af = joy1[4];
    if (emu_active) begin
      ax = mx[7:0];
      ay = my[7:0];
      af = mfire;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      joystick1_x    <= 12'h7F7;
      joystick1_y    <= 12'h7F7;
      joystick2_x    <= 12'h7F7;
      joystick2_y    <= 12'h7F7;
      joystick1_fire <= 1'b1;
      joystick2_fire <= 1'b1;
    end else if (swap) begin
      joystick1_x    <= to_adc12(joy2_x);
      joystick1_y    <= to_adc12(joy2_y);
      joystick2_x    <= to_adc12(ax);
      joystick2_y    <= to_adc12(ay);
      joystick1_fire <= ~joy2[4];
      joystick2_fire <= ~af;
    end else begin
      joystick1_x    <= to_adc12(ax);
      joystick1_y    <= to_adc12(ay);
      joystick2_x    <= to_adc12(joy2_x);
      joystick2_y    <= to_adc12(joy2_y);
      joystick1_fire <= ~af;
      joystick2_fire <= ~joy2[4];
    end
  end

endmodule

// File: tb/tb_bbc_mouse_joystick.sv
// Self-checking bench for bbc_mouse_joystick: vector table, directed
// multi-cycle sequences and a randomized run against a reference model.
module tb_bbc_mouse_joystick;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        recentre;
  logic        mouse_en;
  logic        swap;
  logic [24:0] ps2_mouse;
  logic [15:0] joy1;
  logic [15:0] joy2;
  logic [7:0]  joy1_x;
  logic [7:0]  joy1_y;
  logic [7:0]  joy2_x;
  logic [7:0]  joy2_y;

  logic [11:0] j1x, j1y, j2x, j2y;
  logic        f1, f2, emu;
  logic [11:0] c1x, c1y, c2x, c2y;
  logic        cf1, cf2, cemu;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_sys = ~clk_sys;

  bbc_mouse_joystick u_dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .recentre       (recentre),
    .mouse_en       (mouse_en),
    .swap           (swap),
    .ps2_mouse      (ps2_mouse),
    .joy1           (joy1),
    .joy2           (joy2),
    .joy1_x         (joy1_x),
    .joy1_y         (joy1_y),
    .joy2_x         (joy2_x),
    .joy2_y         (joy2_y),
    .joystick1_x    (j1x),
    .joystick1_y    (j1y),
    .joystick2_x    (j2x),
    .joystick2_y    (j2y),
    .joystick1_fire (f1),
    .joystick2_fire (f2),
    .emu_active     (emu)
  );

  bbc_mouse_joystick #(
    .IDLE_CYCLES (8),
    .DECAY_STEP  (4)
  ) u_ctr (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .recentre       (recentre),
    .mouse_en       (mouse_en),
    .swap           (swap),
    .ps2_mouse      (ps2_mouse),
    .joy1           (joy1),
    .joy2           (joy2),
    .joy1_x         (joy1_x),
    .joy1_y         (joy1_y),
    .joy2_x         (joy2_x),
    .joy2_y         (joy2_y),
    .joystick1_x    (c1x),
    .joystick1_y    (c1y),
    .joystick2_x    (c2x),
    .joystick2_y    (c2y),
    .joystick1_fire (cf1),
    .joystick2_fire (cf2),
    .emu_active     (cemu)
  );

  typedef struct {
    bit          tog;
    logic [7:0]  x;
    bit          xs;
    logic [7:0]  y;
    bit          ys;
    logic [1:0]  btn;
    logic [15:0] j1;
    logic [7:0]  j1x;
    logic [7:0]  j2x;
    bit          sw;
    bit          men;
    logic [11:0] e1x;
    logic [11:0] e1y;
    logic [11:0] e2x;
    bit          ef1;
    bit          eemu;
  } vec_t;

  vec_t tbl[7];

  logic        m_stb;
  int          m_emu, m_mx, m_my, m_fire;
  logic [11:0] e1x, e1y, e2x, e2y;
  logic        ef1, ef2, eemu;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic packet(input logic [7:0] x, input logic xs,
                        input logic [7:0] y, input logic ys,
                        input logic [1:0] btn);
    ps2_mouse = {~ps2_mouse[24], y, x, 2'b00, ys, xs, 2'b00, btn};
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic int adc(input int v);
    int b;
    b = 127 - v;
    return b * 16 + b / 16;
  endfunction

  function automatic int sv8(input logic [7:0] v);
    return v[7] ? int'(v) - 256 : int'(v);
  endfunction

  function automatic int sat(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int delta(input logic s, input logic [7:0] m);
    int raw;
    int d;
    raw = s ? int'(m) - 256 : int'(m);
    d = (raw >= 0) ? raw / 2 : -((1 - raw) / 2);
    if (d > 10) d = 10;
    if (d < -10) d = -10;
    return d;
  endfunction

  // One clock edge of the intended behaviour, from the inputs now applied.
  task automatic model_step();
    int ax, ay, bx, by;
    bit af, bf, acc, clr;
    ax = m_emu ? m_mx : sv8(joy1_x);
    ay = m_emu ? m_my : sv8(joy1_y);
    af = m_emu ? (m_fire != 0) : joy1[4];
    bx = sv8(joy2_x);
    by = sv8(joy2_y);
    bf = joy2[4];
    if (reset) begin
      e1x = 12'h7F7; e1y = 12'h7F7; e2x = 12'h7F7; e2y = 12'h7F7;
      ef1 = 1'b1; ef2 = 1'b1;
    end else begin
      e1x = 12'(adc(swap ? bx : ax));
      e1y = 12'(adc(swap ? by : ay));
      e2x = 12'(adc(swap ? ax : bx));
      e2y = 12'(adc(swap ? ay : by));
      ef1 = !(swap ? bf : af);
      ef2 = !(swap ? af : bf);
    end
    acc = (ps2_mouse[24] != m_stb) && mouse_en;
    clr = reset || joy1 != 0 || recentre || !mouse_en;
    m_stb = ps2_mouse[24];
    if (reset) m_fire = 0;
    else if (acc) m_fire = int'(|ps2_mouse[1:0]);
    if (clr) begin
      m_emu = 0; m_mx = 0; m_my = 0;
    end else if (acc) begin
      m_emu = 1;
      m_mx = sat(m_mx + delta(ps2_mouse[4], ps2_mouse[15:8]));
      m_my = sat(m_my - delta(ps2_mouse[5], ps2_mouse[23:16]));
    end
    eemu = (m_emu != 0);
  endtask

  initial begin
    reset = 1'b1; recentre = 1'b0; mouse_en = 1'b1; swap = 1'b0;
    ps2_mouse = '0; joy1 = '0; joy2 = '0;
    joy1_x = '0; joy1_y = '0; joy2_x = '0; joy2_y = '0;
    m_stb = 1'b0; m_emu = 0; m_mx = 0; m_my = 0; m_fire = 0;

    tbl[0] = '{1'b1, 8'h14, 1'b0, 8'h00, 1'b0, 2'b00, 16'h0, 8'h00, 8'h00,
               1'b0, 1'b1, 12'h757, 12'h7F7, 12'h7F7, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 8'h7E, 1'b0, 8'h80, 1'b1, 2'b01, 16'h0, 8'h00, 8'h00,
               1'b0, 1'b1, 12'h6B6, 12'h757, 12'h7F7, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 8'hEC, 1'b1, 8'h00, 1'b0, 2'b00, 16'h0, 8'h00, 8'h00,
               1'b0, 1'b1, 12'h757, 12'h757, 12'h7F7, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 8'h14, 1'b0, 8'h00, 1'b0, 2'b00, 16'h0010, 8'h40, 8'h00,
               1'b0, 1'b1, 12'h3F3, 12'h7F7, 12'h7F7, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'b00, 16'h0, 8'h00, 8'h7F,
               1'b1, 1'b1, 12'h000, 12'h7F7, 12'h7F7, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 8'h14, 1'b0, 8'h00, 1'b0, 2'b00, 16'h0, 8'h00, 8'h7F,
               1'b0, 1'b0, 12'h7F7, 12'h7F7, 12'h000, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 8'h14, 1'b0, 8'h00, 1'b0, 2'b10, 16'h0, 8'h00, 8'h00,
               1'b0, 1'b1, 12'h757, 12'h7F7, 12'h7F7, 1'b0, 1'b1};

    tick();
    tick();
    check("rst_j1x", j1x, 12'h7F7);
    check("rst_j2y", j2y, 12'h7F7);
    check("rst_fire", {f1, f2}, 2'b11);
    check("rst_emu", {emu, cemu}, 2'b00);
    reset = 1'b0;
    tick();
    check("rst_noacc", emu, 1'b0);

    foreach (tbl[i]) begin
      if (tbl[i].tog) ps2_mouse[24] = ~ps2_mouse[24];
      ps2_mouse[23:0] = {tbl[i].y, tbl[i].x, 2'b00, tbl[i].ys, tbl[i].xs,
                         2'b00, tbl[i].btn};
      joy1 = tbl[i].j1;
      joy1_x = tbl[i].j1x;
      joy2_x = tbl[i].j2x;
      swap = tbl[i].sw;
      mouse_en = tbl[i].men;
      tick();
      tick();
      check($sformatf("vec%0d_j1x", i), j1x, tbl[i].e1x);
      check($sformatf("vec%0d_j1y", i), j1y, tbl[i].e1y);
      check($sformatf("vec%0d_j2x", i), j2x, tbl[i].e2x);
      check($sformatf("vec%0d_fire1", i), f1, tbl[i].ef1);
      check($sformatf("vec%0d_emu", i), emu, tbl[i].eemu);
    end

    joy1 = '0; joy1_x = '0; joy2_x = '0; swap = 1'b0; mouse_en = 1'b1;
    pulse_reset();
    for (int k = 0; k < 3; k++) begin
      packet(8'h14, 1'b0, 8'h00, 1'b0, 2'b00);
      tick();
    end
    tick();
    check("b2b_mx30", j1x, 12'h616);
    for (int k = 0; k < 20; k++) begin
      packet(8'h7E, 1'b0, 8'h00, 1'b0, 2'b00);
      tick();
    end
    tick();
    check("sat_mx_pos", j1x, 12'h000);
    check("sat_emu", emu, 1'b1);
    for (int k = 0; k < 20; k++) begin
      packet(8'h00, 1'b0, 8'h80, 1'b1, 2'b00);
      tick();
    end
    tick();
    check("sat_my_pos", j1y, 12'h000);
    check("sat_mx_hold", j1x, 12'h000);
    for (int k = 0; k < 30; k++) begin
      packet(8'h80, 1'b1, 8'h00, 1'b0, 2'b00);
      tick();
    end
    tick();
    check("sat_mx_neg", j1x, 12'hFFF);

    pulse_reset();
    packet(8'h0A, 1'b0, 8'h00, 1'b0, 2'b00);
    tick();
    repeat (12) tick();
    check("ctr_e12", c1x, 12'h7A7);
    tick();
    check("ctr_e13", c1x, 12'h7B7);
    repeat (15) tick();
    check("ctr_e28", c1x, 12'h7E7);
    tick();
    check("ctr_e29", c1x, 12'h7F7);
    check("ctr_emu", cemu, 1'b1);
    check("nodecay_hold", j1x, 12'h7A7);
    repeat (20) tick();
    check("ctr_stay0", c1x, 12'h7F7);

    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      packet(8'h14, 1'b0, 8'h00, 1'b0, 2'b01);
      tick();
    end
    tick();
    check("mid_mx50", j1x, 12'h4D4);
    check("mid_fire", f1, 1'b0);
    if (ps2_mouse[24]) begin
      packet(8'h00, 1'b0, 8'h00, 1'b0, 2'b01);
      tick();
    end
    packet(8'h14, 1'b0, 8'h00, 1'b0, 2'b01);
    reset = 1'b1;
    tick();
    check("mid_rst_out", {j1x, j1y, f1, emu}, {12'h7F7, 12'h7F7, 2'b10});
    reset = 1'b0;
    tick();
    tick();
    check("mid_noacc", {j1x, emu}, {12'h7F7, 1'b0});

    for (int i = 0; i < 600; i++) begin
      reset = (i == 0) || ($urandom_range(63) == 0);
      recentre = ($urandom_range(31) == 0);
      mouse_en = ($urandom_range(15) != 0);
      if ($urandom_range(7) == 0) swap = ~swap;
      joy1 = ($urandom_range(15) == 0) ? 16'($urandom) : 16'h0;
      joy2 = 16'($urandom);
      joy1_x = 8'($urandom);
      joy1_y = 8'($urandom);
      joy2_x = 8'($urandom);
      joy2_y = 8'($urandom);
      ps2_mouse[23:0] = 24'($urandom);
      if ($urandom_range(1) == 1) ps2_mouse[24] = ~ps2_mouse[24];
      model_step();
      tick();
      check($sformatf("rand%0d", i), {j1x, j1y, j2x, j2y, f1, f2, emu},
            {e1x, e1y, e2x, e2y, ef1, ef2, eemu});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bbc_mouse_joystick.md
# bbc_mouse_joystick

Analog-input front end for the BBC Micro core. It converts the HPS PS/2 mouse packet stream and the two HPS analog joysticks into the four 12-bit ADC channels and two fire lines that the core's uPD7002 model consumes. It sits between `hps_io` and `bbc_micro_core`, and replaces the inline mouse accumulator and joystick mapping in the top level. It adds:

- arbitration between mouse and joystick;
- channel swap;
- optional self-centring of the mouse-emulated stick.

## Interface

Parameters:

- `DELTA_MAX`, default 10: per-packet delta clamp (magnitude).
- `IDLE_CYCLES`, default 0: number of idle `clk_sys` cycles after the last mouse packet before self-centring starts. 0 disables self-centring.
- `DECAY_STEP`, default 65536: number of `clk_sys` cycles between successive 1-LSB centring steps.

Ports:

- `clk_sys` in, 1: system clock; the single clock domain.
- `reset` in, 1: reset is synchronous and active-high.
- `recentre` in, 1: core `reset_req`. Same effect as digital activity: clears `emu_active` and zeroes the position.
- `mouse_en` in, 1: 1 = mouse may drive joystick A (OSD "Mouse as Joystick" = Yes).
- `swap` in, 1: exchange joystick A and B onto the core channels.
- `ps2_mouse` in, 25: HPS mouse packet.
  - [24] toggle strobe.
  - [23:16] Y.
  - [15:8] X.
  - [5] Y sign.
  - [4] X sign.
  - [1:0] buttons.
- `joy1` in, 16: digital joystick 1; [4] is fire.
- `joy2` in, 16: digital joystick 2; [4] is fire.
- `joy1_x`, `joy1_y` in, 8 each: analog stick 1, signed.
- `joy2_x`, `joy2_y` in, 8 each: analog stick 2, signed.
- `joystick1_x`, `joystick1_y` out, 12 each: core channel 1 ADC value.
- `joystick2_x`, `joystick2_y` out, 12 each: core channel 2 ADC value.
- `joystick1_fire`, `joystick2_fire` out, 1 each: active-low fire.
- `emu_active` out, 1: mouse currently drives joystick A.

## Operation

- **Packet detect.** `stb_q` is a register holding the last sampled `ps2_mouse[24]`. A packet is accepted when `ps2_mouse[24] != stb_q` and `mouse_en` = 1. On reset, `stb_q` loads the current `ps2_mouse[24]`, so no packet is accepted in the cycle after reset.
- **Delta.** `dx = {ps2_mouse[4], ps2_mouse[15:8]} >>> 1`, 9-bit signed (arithmetic shift). `dy` is formed the same way from `[5]` and `[23:16]`. Each delta is clamped to [-DELTA_MAX, +DELTA_MAX].
- **Position.** `mx` and `my` are 9-bit signed, computed at 10 bits internally.
  - `mx <= sat(mx + dx)`.
  - `my <= sat(my - dy)`, so mouse-up moves the stick up.
  - `sat` saturates to [-128, +127]; the position never wraps.
- **Mode.** An accepted packet sets `emu_active`.
- **Clear conditions.** Any of the following forces `emu_active` = 0, `mx` = 0, `my` = 0:
  - `joy1` != 0;
  - `recentre`;
  - `mouse_en` = 0;
  - `reset`.
- **Clear priority.** The clear conditions override a packet accepted in the same cycle. The strobe is still consumed (`stb_q` updates).
- **Self-centring** (only when IDLE_CYCLES > 0):
  - States: IDLE_WAIT, then DECAY.
  - An idle counter restarts on every accepted packet.
  - After IDLE_CYCLES idle cycles, the FSM enters DECAY. Every DECAY_STEP cycles, each nonzero axis moves 1 toward 0.
  - Any packet returns the FSM to IDLE_WAIT.
  - Once both axes reach 0, the FSM stays in DECAY with no further effect.
  - `emu_active` is not changed by decay.
- **Source select.**
  - Joystick A = `emu_active` ? (`mx[7:0]`, `my[7:0]`, mouse fire = `|ps2_mouse[1:0]` of the last packet, held) : (`joy1_x`, `joy1_y`, `joy1[4]`).
  - Joystick B = (`joy2_x`, `joy2_y`, `joy2[4]`).
- **Routing.** `swap` = 0: A goes to core channel 1 and B to channel 2. `swap` = 1: the reverse.
- **ADC mapping** of signed value v: `b = 8'hFF - {~v[7], v[6:0]}`, output `{b, b[7:4]}`. Reference points:
  - v = 0 gives 0x7F7.
  - v = +127 gives 0x000.
  - v = -128 gives 0xFFF.
- **Fire.** Fire outputs are the inverted selected fire.

## Timing

- All outputs are registered.
- Reset values:
  - ADC outputs 0x7F7;
  - fire outputs 1;
  - `emu_active` 0;
  - `mx`, `my` 0;
  - FSM in IDLE_WAIT with counters 0.
- Latency, strobe toggle to updated ADC outputs: 2 `clk_sys` edges. Edge 1 updates the position; edge 2 updates the output.
- Latency, `joy*`, `swap` or `mouse_en` change to outputs: 1 edge.
- Back-to-back toggles on consecutive cycles are each accepted. No rate limit applies.

## Structure

- Package `bbc_analog_pkg`:
  - constants `POS_MIN` = -128 and `POS_MAX` = 127;
  - function `to_adc12(logic signed [7:0])`;
  - typedef `axis_t` (9-bit signed);
  - enum `centre_state_e` {IDLE_WAIT, DECAY}.
- Sub-module `mouse_axis`, instantiated twice: delta clamp, saturating accumulate, clear, decay step.
- The centring FSM and its counters are shared between the two axes and live in the top of this block.

## Test plan

- **Packet accumulate.** `mouse_en` = 1. Toggle with X = 0x14, sign 0 (dx = 10): `joystick1_x` = `to_adc12(10)` = 0x757 two cycles later, and `emu_active` = 1.
- **Clamp and saturate.** 20 packets, each X = 0x7E (dx clamped to 10): `mx` stops at 127 and `joystick1_x` = 0x000. Packets with Y sign 1, Y = 0x80 (dy = -64, clamped to -10; `my` increases by 10 per packet): `my` saturates at 127.
- **Digital override.** In the same cycle as a toggle, `joy1` = 0x0010: `emu_active` = 0, `mx` = 0, `joystick1_x` = `to_adc12(joy1_x)`, and `joystick1_fire` = 0.
- **Swap.** `joy1_x` = 0x00, `joy2_x` = 0x7F, `swap` = 1: `joystick1_x` = 0x000 and `joystick2_x` = 0x7F7.
- **Self-centring.** IDLE_CYCLES = 8, DECAY_STEP = 4, `mx` = 5 after a packet: `mx` reaches 0 exactly 8 + 5×4 cycles later and `emu_active` stays 1.
- **Reset mid-stream.** Assert `reset` with `mx` = 50 and the strobe toggled: outputs return to 0x7F7 with fire 1, and no packet is accepted on the first cycle after reset.
